// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kbd_pkg
// Description : Shared constants, FSM state type and BCD helpers for the
//               PS/2 keyboard display controller.
// Revision    : 1.0 - initial release
// ============================================================================
package kbd_pkg;

    // PS/2 set-2 prefix bytes
    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    // Controller states: no key held, key displayed, break prefix pending
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        BRK  = 2'd2
    } state_t;

    // One decimal digit of the keypress counter
    typedef logic [3:0] bcd_t;

    // Two-digit BCD increment without range wrap; the caller handles the
    // configured maximum.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        bcd_t tens;
        bcd_t units;
        tens  = v[7:4];
        units = v[3:0];
        if (units == 4'd9) begin
            return {tens + 4'd1, 4'd0};
        end
        return {tens, units + 4'd1};
    endfunction

endpackage : kbd_pkg
`default_nettype wire

// File: rtl/kbd_ascii_rom.sv
`default_nettype none
// ============================================================================
// Module      : kbd_ascii_rom
// Description : Combinational PS/2 set-2 scan code to ASCII lookup.
//               Letters map to uppercase, digits and space are mapped,
//               every other code returns 8'h00.
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_ascii_rom (
    input  logic [7:0] i_code,
    output logic [7:0] o_ascii
);

    // Scan code to character table
    always_comb begin
        o_ascii = 8'h00;
        case (i_code)
            8'h1C: o_ascii = 8'h41; // A
            8'h32: o_ascii = 8'h42; // B
            8'h21: o_ascii = 8'h43; // C
            8'h23: o_ascii = 8'h44; // D
            8'h24: o_ascii = 8'h45; // E
            8'h2B: o_ascii = 8'h46; // F
            8'h34: o_ascii = 8'h47; // G
            8'h33: o_ascii = 8'h48; // H
            8'h43: o_ascii = 8'h49; // I
            8'h3B: o_ascii = 8'h4A; // J
            8'h42: o_ascii = 8'h4B; // K
            8'h4B: o_ascii = 8'h4C; // L
            8'h3A: o_ascii = 8'h4D; // M
            8'h31: o_ascii = 8'h4E; // N
            8'h44: o_ascii = 8'h4F; // O
            8'h4D: o_ascii = 8'h50; // P
            8'h15: o_ascii = 8'h51; // Q
            8'h2D: o_ascii = 8'h52; // R
            8'h1B: o_ascii = 8'h53; // S
            8'h2C: o_ascii = 8'h54; // T
            8'h3C: o_ascii = 8'h55; // U
            8'h2A: o_ascii = 8'h56; // V
            8'h1D: o_ascii = 8'h57; // W
            8'h22: o_ascii = 8'h58; // X
            8'h35: o_ascii = 8'h59; // Y
            8'h1A: o_ascii = 8'h5A; // Z
            8'h45: o_ascii = 8'h30; // 0
            8'h16: o_ascii = 8'h31; // 1
            8'h1E: o_ascii = 8'h32; // 2
            8'h26: o_ascii = 8'h33; // 3
            8'h25: o_ascii = 8'h34; // 4
            8'h2E: o_ascii = 8'h35; // 5
            8'h36: o_ascii = 8'h36; // 6
            8'h3D: o_ascii = 8'h37; // 7
            8'h3E: o_ascii = 8'h38; // 8
            8'h46: o_ascii = 8'h39; // 9
            8'h29: o_ascii = 8'h20; // space
            default: o_ascii = 8'h00;
        endcase
    end

endmodule : kbd_ascii_rom
`default_nettype wire

// File: rtl/kbd_disp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kbd_disp_ctrl
// Description : Scan-code sequencer between the PS/2 byte receiver and the
//               two-digit seven-segment decoders. Tracks make/break codes,
//               holds the displayed key, its ASCII value and a BCD
//               keypress count. Optional E0 extended-key tracking is
//               enabled by defining KBD_DISP_EXT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_disp_ctrl
    import kbd_pkg::*;
#(
    parameter int CNT_MAX = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] code,
    output logic [7:0] ascii,
    output logic [7:0] cnt,
    output logic       disp_on,
    output logic       ext
);

    localparam logic [7:0] c_cnt_max_bcd = {4'(CNT_MAX / 10), 4'(CNT_MAX % 10)};

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_ready;
    logic [7:0] r_code;
    logic [7:0] r_ascii;
    logic [7:0] r_cnt;
    logic       r_disp_on;
    logic       w_xfer;
    logic       w_load;
    logic       w_release;
    logic       w_same_key;
    logic [7:0] w_rom_ascii;
    logic       w_pre;      // extended prefix pending for the current byte
    logic       w_ext_q;    // held key was extended

`ifdef KBD_DISP_EXT_EN
    logic       r_pre;
    logic       r_ext;
    logic       w_pre_nxt;
    assign w_pre   = r_pre;
    assign w_ext_q = r_ext;
`else
    assign w_pre   = 1'b0;
    assign w_ext_q = 1'b0;
`endif

    kbd_ascii_rom u_rom (
        .i_code  (in_data),
        .o_ascii (w_rom_ascii)
    );

    assign w_xfer     = in_valid & r_ready;
    // Same physical key: code matches and the extended flag agrees
    assign w_same_key = r_disp_on && (in_data == r_code) && (w_ext_q == w_pre);

    // Next-state decode: load a new key, release the held key, or hold
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_release   = 1'b0;
`ifdef KBD_DISP_EXT_EN
        w_pre_nxt   = r_pre;
`endif
        if (w_xfer) begin
            if (in_data == EXT_CODE) begin
`ifdef KBD_DISP_EXT_EN
                w_pre_nxt = 1'b1;
`endif
            end else begin
                case (r_state)
                    BRK: begin
`ifdef KBD_DISP_EXT_EN
                        w_pre_nxt = 1'b0;
`endif
                        if (w_same_key) begin
                            w_release   = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = r_disp_on ? HELD : IDLE;
                        end
                    end
                    default: begin
                        if (in_data == BREAK_CODE) begin
                            // prefix flag survives so E0 F0 X matches extended keys
                            w_state_nxt = BRK;
                        end else begin
`ifdef KBD_DISP_EXT_EN
                            w_pre_nxt   = 1'b0;
`endif
                            w_state_nxt = HELD;
                            w_load      = !w_same_key;
                        end
                    end
                endcase
            end
        end
    end

    // State, handshake and display registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_code    <= 8'h00;
            r_ascii   <= 8'h00;
            r_cnt     <= 8'h00;
            r_disp_on <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // one-cycle bubble after every accepted byte
            r_ready <= ~w_xfer;
            if (w_load) begin
                r_code    <= in_data;
                r_ascii   <= w_rom_ascii;
                r_disp_on <= 1'b1;
                r_cnt     <= (r_cnt == c_cnt_max_bcd) ? 8'h00 : bcd_inc(r_cnt);
            end else if (w_release) begin
                r_disp_on <= 1'b0;
            end
        end
    end

`ifdef KBD_DISP_EXT_EN
    // Extended prefix flag and extended attribute of the held key
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= 1'b0;
            r_ext <= 1'b0;
        end else begin
            r_pre <= w_pre_nxt;
            if (w_load) begin
                r_ext <= r_pre;
            end
        end
    end
`endif

    assign in_ready = r_ready;
    assign code     = r_code;
    assign ascii    = r_ascii;
    assign cnt      = r_cnt;
    assign disp_on  = r_disp_on;
    assign ext      = w_ext_q;

endmodule : kbd_disp_ctrl
`default_nettype wire

// File: tb/tb_kbd_disp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kbd_disp_ctrl
// Description : Self-checking bench for kbd_disp_ctrl. A behavioural model
//               of held key / count / handshake is compared every cycle,
//               plus directed literal checks. Honours KBD_DISP_EXT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kbd_disp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [7:0] code;
    logic [7:0] ascii;
    logic [7:0] cnt;
    logic       disp_on;
    logic       ext;

    int n_chk  = 0;
    int n_pass = 0;

    kbd_disp_ctrl #(.CNT_MAX(99)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .code     (code),
        .ascii    (ascii),
        .cnt      (cnt),
        .disp_on  (disp_on),
        .ext      (ext)
    );

    always #5 clk = ~clk;

    // ---------------- reference tables ----------------
    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool    [12] = '{8'h1C, 8'h32, 8'h16, 8'h45, 8'h29, 8'h76, 8'hF0,
                                 8'hF0, 8'hE0, 8'h1C, 8'h75, 8'hF0};

    function automatic logic [7:0] ref_ascii(input logic [7:0] sc);
        for (int i = 0; i < 26; i++) if (letters[i] == sc) return 8'h41 + 8'(i);
        for (int i = 0; i < 10; i++) if (digits[i] == sc) return 8'h30 + 8'(i);
        if (sc == 8'h29) return 8'h20;
        return 8'h00;
    endfunction

    // ---------------- behavioural model ----------------
    bit         armed   = 0;
    bit         m_rdy   = 0;
    bit         m_held  = 0;
    bit         m_brk   = 0;
    bit         m_ext   = 0;
    bit         m_pre   = 0;
    logic [7:0] m_code  = 8'h00;
    int         m_count = 0;

    task automatic model_byte(input logic [7:0] d);
        if (d == 8'hE0) begin
`ifdef KBD_DISP_EXT_EN
            m_pre = 1;
`endif
        end else if (m_brk) begin
            m_brk = 0;
            if (m_held && d == m_code && m_ext == m_pre) m_held = 0;
            m_pre = 0;
        end else if (d == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (!(m_held && d == m_code && m_ext == m_pre)) begin
                m_code  = d;
                m_ext   = m_pre;
                m_held  = 1;
                m_count = (m_count == 99) ? 0 : m_count + 1;
            end
            m_pre = 0;
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [7:0] d);
        bit acc;
        if (r) begin
            armed = 1; m_rdy = 0; m_held = 0; m_brk = 0; m_ext = 0; m_pre = 0;
            m_code = 8'h00; m_count = 0;
        end else begin
            acc   = v && m_rdy;
            m_rdy = !acc;
            if (acc) model_byte(d);
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    endtask

    // Model advance on each edge, compare on the following falling edge
    initial begin
        logic [7:0] e_cnt;
        forever begin
            @(posedge clk);
            model_step(rst, in_valid, in_data);
            @(negedge clk);
            if (armed) begin
                e_cnt = {4'(m_count / 10), 4'(m_count % 10)};
                chk("m_code",    code,            m_code);
                chk("m_ascii",   ascii,           ref_ascii(m_code));
                chk("m_cnt",     cnt,             e_cnt);
                chk("m_disp_on", {7'd0, disp_on}, {7'd0, m_held});
                chk("m_ext",     {7'd0, ext},     {7'd0, m_ext});
                chk("m_ready",   {7'd0, in_ready},{7'd0, m_rdy});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // A two-cycle valid window always contains exactly one accepting edge.
    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_code",  code,  8'h00);
        chk("rst_ascii", ascii, 8'h00);
        chk("rst_cnt",   cnt,   8'h00);
        chk("rst_disp",  {7'd0, disp_on}, 8'h00);
        chk("rst_ready", {7'd0, in_ready}, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;

        // first make
        send(8'h1C);
        @(negedge clk);
        chk("t1_code",  code,  8'h1C);
        chk("t1_ascii", ascii, 8'h41);
        chk("t1_cnt",   cnt,   8'h01);
        chk("t1_disp",  {7'd0, disp_on}, 8'h01);
        chk("t1_ready_bubble", {7'd0, in_ready}, 8'h00);

        // typematic repeats then break
        repeat (5) send(8'h1C);
        send(8'hF0); send(8'h1C);
        @(negedge clk);
        chk("t2_cnt",  cnt,  8'h01);
        chk("t2_disp", {7'd0, disp_on}, 8'h00);
        chk("t2_code", code, 8'h1C);

        // roll-over to a second key
        do_reset();
        send(8'h1C); send(8'h32); send(8'hF0); send(8'h1C);
        @(negedge clk);
        chk("t3_code",  code,  8'h32);
        chk("t3_ascii", ascii, 8'h42);
        chk("t3_cnt",   cnt,   8'h02);
        chk("t3_disp",  {7'd0, disp_on}, 8'h01);
        send(8'hF0); send(8'h32);
        @(negedge clk);
        chk("t3_rel", {7'd0, disp_on}, 8'h00);

        // unmapped key and space
        send(8'h76);
        @(negedge clk);
        chk("unmapped_ascii", ascii, 8'h00);
        send(8'h29);
        @(negedge clk);
        chk("space_ascii", ascii, 8'h20);

        // extended prefix
        do_reset();
        send(8'hE0); send(8'h75);
        @(negedge clk);
        chk("e_code", code, 8'h75);
        chk("e_cnt",  cnt,  8'h01);
`ifdef KBD_DISP_EXT_EN
        chk("e_ext",  {7'd0, ext}, 8'h01);
        send(8'hF0); send(8'h75);
        @(negedge clk);
        chk("e_plain_break", {7'd0, disp_on}, 8'h01);
        send(8'hE0); send(8'hF0); send(8'h75);
        @(negedge clk);
        chk("e_ext_break", {7'd0, disp_on}, 8'h00);
`else
        chk("e_ext",  {7'd0, ext}, 8'h00);
        send(8'hF0); send(8'h75);
        @(negedge clk);
        chk("e_break", {7'd0, disp_on}, 8'h00);
`endif

        // reset while a break is pending, with a byte offered
        do_reset();
        send(8'h1C); send(8'hF0);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h1C;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("rb_code", code, 8'h00);
        chk("rb_cnt",  cnt,  8'h00);
        chk("rb_disp", {7'd0, disp_on}, 8'h00);
        chk("rb_ready", {7'd0, in_ready}, 8'h00);
        send(8'h1C);
        @(negedge clk);
        chk("rb_after", cnt, 8'h01);

        // count across decades and wrap
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            send(8'h16); send(8'hF0); send(8'h16);
            if (i == 9)   begin @(negedge clk); chk("cnt_09", cnt, 8'h09); end
            if (i == 10)  begin @(negedge clk); chk("cnt_10", cnt, 8'h10); end
            if (i == 99)  begin @(negedge clk); chk("cnt_99", cnt, 8'h99); end
            if (i == 100) begin @(negedge clk); chk("cnt_00", cnt, 8'h00); end
        end

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                in_valid = 1'($urandom_range(0, 1));
                in_data  = pool[$urandom_range(0, 11)];
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
                rst = 1'b0;
                in_valid = 1'b0;
            end
            send(pool[$urandom_range(0, 11)]);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_kbd_disp_ctrl
`default_nettype wire

// File: doc/kbd_disp_ctrl.md
# kbd_disp_ctrl

Sequencing controller between the PS/2 byte receiver and the pair-of-digit seven-segment decoders in the keyboard display experiment. It consumes raw scan-code bytes and tracks make/break (F0) and optional extended (E0) prefixes. It produces the held key's scan code, its ASCII value, a two-digit BCD keypress count and a display-enable that blanks the code and ASCII digit pairs when no key is held. Each 8-bit output feeds one two-digit decoder; `disp_on` drives the decoders' enable input.

## Interface
- `CNT_MAX`, 99, last BCD count value before wrapping to 0. Legal range 1..99.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  receiver presents a byte.
- `in_data`  in  8  PS/2 set-2 byte.
- `in_ready`  out  1  controller accepts the byte this cycle.
- `code`  out  8  scan code of the held key.
- `ascii`  out  8  ASCII of `code`; 8'h00 if unmapped.
- `cnt`  out  8  BCD keypress count: `cnt[7:4]` is tens, `cnt[3:0]` is units.
- `disp_on`  out  1  high while a key is held; drives the code/ASCII decoder enable.
- `ext`  out  1  held key was E0-prefixed. Constant 0 when the feature is compiled out.

## Operation
- Transfer happens when `in_valid && in_ready` at a rising edge.
- `in_ready` is registered. It drops for exactly one cycle after each accepted byte (processing bubble), then returns high.
- FSM states:
  - IDLE: no key held.
  - HELD: key displayed.
  - BRK: F0 seen, waiting for the released code.
- IDLE, make byte M (not F0/E0):
  - `code`<=M, `ascii`<=lookup(M), `disp_on`<=1.
  - `cnt` increments.
  - Next state HELD.
- HELD, byte == `code` (typematic repeat): no output change, no count.
- HELD, different make byte: replace `code`/`ascii`, `cnt` increments, stay HELD.
- IDLE or HELD, F0: go to BRK with no output change.
- BRK, next byte B:
  - B == `code` and `disp_on`=1: `disp_on`<=0, go IDLE.
  - Otherwise (release of a non-displayed key, or stray break): byte is consumed, outputs unchanged. Return to HELD if `disp_on`, else IDLE.
- `code`/`ascii` keep their last values while blanked; only `disp_on` drops.
- Count arithmetic: BCD. Units 9 -> 0 with carry into tens. `CNT_MAX` -> 00 wraps silently.
- Simultaneous `rst` and transfer: reset wins; the byte is dropped.
- Reset mid-sequence (e.g. in BRK): returns to IDLE and the pending prefix is discarded.

## Timing
- Reset values: `code`=0, `ascii`=0, `cnt`=0, `disp_on`=0, `ext`=0, `in_ready`=0.
- `in_ready` rises on the first edge after `rst` deasserts.
- Latency: byte accepted at edge N; all outputs reflect it after edge N. `in_ready`=0 during cycle N..N+1, high after edge N+1.
- Maximum throughput: one byte per two cycles.
- All outputs are registered; `ascii` is registered from the lookup of `in_data`.

## Configuration
- `KBD_DISP_EXT_EN` defined:
  - E0 sets an internal prefix flag with no other state change.
  - The next make loads `ext`<=1 alongside `code`. A non-prefixed make loads `ext`<=0.
  - E0 F0 X releases only if X == `code` and `ext`=1.
  - The flag clears after the following non-E0 byte.
  - An extended make whose code equals a held non-extended code counts as a new key.
- Not defined:
  - E0 is consumed and ignored.
  - `ext` is tied to 0.
  - No prefix flag is synthesized.

## Structure
- Shared package `kbd_pkg`:
  - `BREAK_CODE`=8'hF0, `EXT_CODE`=8'hE0.
  - FSM state typedef {IDLE, HELD, BRK}.
  - BCD digit type.
- Sub-module `kbd_ascii_rom`: combinational set-2 -> ASCII lookup.
  - Maps letters to uppercase, e.g. 1C->8'h41 'A', 32->8'h42 'B'.
  - Maps digits, e.g. 16->8'h31 '1', 45->8'h30 '0'.
  - Maps space 29->8'h20.
  - Everything else -> 8'h00.

## Test plan
- Reset then send 1C: `code`=1C, `ascii`=41, `cnt`=01, `disp_on`=1; `in_ready` low for one cycle after acceptance.
- Send 1C ×5 (repeat), then F0 1C: `cnt` stays 01; `disp_on`=0 after the final byte; `code` still 1C.
- Send 1C, then 32 with no break, then F0 1C: `code`=32, `cnt`=02, `disp_on` stays 1; then F0 32 -> `disp_on`=0.
- Issue 99 make/break pairs of 16, then one more: `cnt` steps 09->10 correctly, reaches 99, then wraps to 00.
- With `KBD_DISP_EXT_EN`: send E0 75 -> `ext`=1, `code`=75, `cnt`+1; send F0 75 -> no release; send E0 F0 75 -> `disp_on`=0. Without the macro, E0 is ignored and `ext`=0.
- Assert `rst` in BRK after F0, with `in_valid` high on the reset cycle: all outputs return to reset values and the byte is not counted.
